// File: rtl/flex_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flex_counter_pkg
//  Description : Shared types and limits for the flex_counter block.
//                Optional feature macro: FLEX_COUNTER_PRESCALE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package flex_counter_pkg;

  // Counting mode: continuous wrap or stop-at-terminal one-shot
  typedef enum logic {
    MODE_WRAP    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_t;

  // Counter state: stepping allowed, or halted after a one-shot terminal
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Legal parameter ranges
  localparam int unsigned PRESCALE_MIN = 2;
  localparam int unsigned PRESCALE_MAX = 256;
  localparam int unsigned NUM_BITS_MIN = 2;
  localparam int unsigned NUM_BITS_MAX = 32;

endpackage : flex_counter_pkg
`default_nettype wire

// File: rtl/flex_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : flex_prescaler
//  Description : Divides enabled cycles by PRESCALE. tick is asserted on the
//                enabled cycle where the internal count reaches PRESCALE-1,
//                after which the count returns to 0. The count holds while
//                en is low; clr and rst return it to 0.
//                Used only when FLEX_COUNTER_PRESCALE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module flex_prescaler
  import flex_counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == C_LAST);
  assign tick    = en && at_last;

  // Next prescale count: clear wins, otherwise advance only on enabled cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : (cnt_q + C_ONE);
    end
  end

  // Prescale count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : flex_prescaler
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
//  Module      : flex_counter
//  Description : Parametrised up/down counter with programmable terminal
//                value, parallel load, synchronous clear, wrap / one-shot
//                modes and status flags.
//                Optional feature macro: FLEX_COUNTER_PRESCALE_EN
//                (when defined, a step needs PRESCALE enabled cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module flex_counter
  import flex_counter_pkg::*;
#(
  parameter int NUM_BITS = 4,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic                up_down,
  input  logic                mode,
  input  logic                load,
  input  logic [NUM_BITS-1:0] load_val,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count,
  output logic                at_max,
  output logic                at_zero,
  output logic                wrap,
  output logic                done
);

  // State encodings
  localparam logic [0:0] S_RUN  = ST_RUN;
  localparam logic [0:0] S_HALT = ST_HALT;

  localparam logic [NUM_BITS-1:0] C_ONE = {{(NUM_BITS-1){1'b0}}, 1'b1};

  // Reject illegal parameterisations at elaboration
  if ((NUM_BITS < NUM_BITS_MIN) || (NUM_BITS > NUM_BITS_MAX) ||
      (PRESCALE < PRESCALE_MIN) || (PRESCALE > PRESCALE_MAX)) begin : g_param_check
    $error("flex_counter: NUM_BITS or PRESCALE out of range");
  end

  logic [NUM_BITS-1:0] count_q;
  logic [NUM_BITS-1:0] count_d;
  logic                wrap_q;
  logic                wrap_d;
  logic                done_q;
  logic                done_d;
  logic [0:0]          state_q;
  logic [0:0]          state_d;

  logic                run_en;
  logic                step;
  logic                terminal;
  logic                oneshot;

  // Enable request qualified by state; HALT ignores count_enable entirely
  assign run_en = count_enable && (state_q == S_RUN);

`ifdef FLEX_COUNTER_PRESCALE_EN
  logic presc_clr;
  logic presc_tick;

  // Load restarts the interval as well as clear
  assign presc_clr = clear || load;

  flex_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (run_en),
    .tick (presc_tick)
  );

  assign step = presc_tick;
`else
  assign step = run_en;
`endif

  // Terminal test uses >= when counting up so an over-range load still wraps
  // instead of running on to the natural overflow.
  assign oneshot  = (mode == MODE_ONESHOT);
  assign terminal = up_down ? (count_q >= rollover_val) : (count_q == '0);

  // Next-state logic: clear > load > step; wrap is a single-cycle pulse
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    done_d  = done_q;
    state_d = state_q;
    if (clear) begin
      count_d = '0;
      done_d  = 1'b0;
      state_d = S_RUN;
    end else if (load) begin
      count_d = load_val;
      done_d  = 1'b0;
      state_d = S_RUN;
    end else if (step) begin
      if (terminal) begin
        wrap_d = 1'b1;
        if (oneshot) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end else begin
          count_d = up_down ? '0 : rollover_val;
        end
      end else begin
        count_d = up_down ? (count_q + C_ONE) : (count_q - C_ONE);
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      state_q <= S_RUN;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign done    = done_q;
  assign at_max  = (count_q == rollover_val);
  assign at_zero = (count_q == '0);

endmodule : flex_counter
`default_nettype wire

// File: tb/tb_flex_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flex_counter
//  Description : Directed-vector bench for flex_counter (NUM_BITS=4,
//                PRESCALE=4). Stimulus pushes hand-computed expectations into
//                a scoreboard queue; a monitor pops and compares after each
//                clock edge. Honours FLEX_COUNTER_PRESCALE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flex_counter;

  typedef struct {
    string      nm;
    logic [3:0] c;
    logic       w;
    logic       d;
    logic       am;
    logic       az;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       count_enable;
  logic       up_down;
  logic       mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] rollover_val;
  logic [3:0] count;
  logic       at_max;
  logic       at_zero;
  logic       wrap;
  logic       done;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  flex_counter #(
    .NUM_BITS (4),
    .PRESCALE (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .count_enable (count_enable),
    .up_down      (up_down),
    .mode         (mode),
    .load         (load),
    .load_val     (load_val),
    .rollover_val (rollover_val),
    .count        (count),
    .at_max       (at_max),
    .at_zero      (at_zero),
    .wrap         (wrap),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic cyc(input string nm, input logic r, input logic cl, input logic ld,
                     input logic en, input logic ud, input logic md,
                     input logic [3:0] lv, input logic [3:0] rv,
                     input logic [3:0] ec, input logic ew, input logic ed,
                     input logic eam, input logic eaz);
    exp_t e;
    @(negedge clk);
    rst          = r;
    clear        = cl;
    load         = ld;
    count_enable = en;
    up_down      = ud;
    mode         = md;
    load_val     = lv;
    rollover_val = rv;
    e.nm = nm; e.c = ec; e.w = ew; e.d = ed; e.am = eam; e.az = eaz;
    sb.push_back(e);
  endtask

  // Monitor: every edge with a pending expectation is one comparison
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if ({count, wrap, done, at_max, at_zero} !== {e.c, e.w, e.d, e.am, e.az}) begin
          n_miss++;
          $display("FAIL %s: got count=%0d wrap=%b done=%b at_max=%b at_zero=%b, want count=%0d wrap=%b done=%b at_max=%b at_zero=%b",
                   e.nm, count, wrap, done, at_max, at_zero, e.c, e.w, e.d, e.am, e.az);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; load = 1'b0; count_enable = 1'b0;
    up_down = 1'b1; mode = 1'b0; load_val = 4'd0; rollover_val = 4'd5;

    //  nm            r  cl ld en ud md lv  rv   cnt w  d  am az
    cyc("reset_a",    1, 0, 0, 0, 1, 0, 0,  5,   0,  0, 0, 0, 1);
    cyc("reset_b",    1, 0, 0, 0, 1, 0, 0,  5,   0,  0, 0, 0, 1);

`ifdef FLEX_COUNTER_PRESCALE_EN
    // Enable held: one step per four enabled cycles
    for (int i = 1; i <= 12; i++) begin
      cyc("presc_run", 0, 0, 0, 1, 1, 0, 0, 15, 4'(i / 4), 0, 0, 0, (i < 4));
    end
    cyc("presc_p1",   0, 0, 0, 1, 1, 0, 0, 15,   3,  0, 0, 0, 0);
    cyc("presc_p2",   0, 0, 0, 1, 1, 0, 0, 15,   3,  0, 0, 0, 0);
    // Load mid-interval restarts the interval
    cyc("presc_load", 0, 0, 1, 1, 1, 0, 8, 15,   8,  0, 0, 0, 0);
    cyc("presc_r1",   0, 0, 0, 1, 1, 0, 0, 15,   8,  0, 0, 0, 0);
    cyc("presc_r2",   0, 0, 0, 1, 1, 0, 0, 15,   8,  0, 0, 0, 0);
    cyc("presc_r3",   0, 0, 0, 1, 1, 0, 0, 15,   8,  0, 0, 0, 0);
    cyc("presc_step", 0, 0, 0, 1, 1, 0, 0, 15,   9,  0, 0, 0, 0);
    // Prescaler holds while enable is low
    cyc("presc_hold", 0, 0, 0, 0, 1, 0, 0, 15,   9,  0, 0, 0, 0);
    cyc("presc_h1",   0, 0, 0, 1, 1, 0, 0, 15,   9,  0, 0, 0, 0);
    cyc("presc_h2",   0, 0, 0, 1, 1, 0, 0, 15,   9,  0, 0, 0, 0);
    cyc("presc_h3",   0, 0, 0, 1, 1, 0, 0, 15,   9,  0, 0, 0, 0);
    cyc("presc_h4",   0, 0, 0, 1, 1, 0, 0, 15,  10,  0, 0, 0, 0);
`else
    // Wrap up with rollover 5
    cyc("wrap_up1",   0, 0, 0, 1, 1, 0, 0,  5,   1,  0, 0, 0, 0);
    cyc("wrap_up2",   0, 0, 0, 1, 1, 0, 0,  5,   2,  0, 0, 0, 0);
    cyc("wrap_up3",   0, 0, 0, 1, 1, 0, 0,  5,   3,  0, 0, 0, 0);
    cyc("wrap_up4",   0, 0, 0, 1, 1, 0, 0,  5,   4,  0, 0, 0, 0);
    cyc("wrap_up5",   0, 0, 0, 1, 1, 0, 0,  5,   5,  0, 0, 1, 0);
    cyc("wrap_up0",   0, 0, 0, 1, 1, 0, 0,  5,   0,  1, 0, 0, 1);
    cyc("wrap_up1b",  0, 0, 0, 1, 1, 0, 0,  5,   1,  0, 0, 0, 0);
    cyc("idle",       0, 0, 0, 0, 1, 0, 0,  5,   1,  0, 0, 0, 0);

    // One-shot down from 3
    cyc("os_load3",   0, 0, 1, 0, 0, 1, 3,  5,   3,  0, 0, 0, 0);
    cyc("os_dn2",     0, 0, 0, 1, 0, 1, 0,  5,   2,  0, 0, 0, 0);
    cyc("os_dn1",     0, 0, 0, 1, 0, 1, 0,  5,   1,  0, 0, 0, 0);
    cyc("os_dn0",     0, 0, 0, 1, 0, 1, 0,  5,   0,  0, 0, 0, 1);
    cyc("os_term",    0, 0, 0, 1, 0, 1, 0,  5,   0,  1, 1, 0, 1);
    cyc("os_halt1",   0, 0, 0, 1, 0, 1, 0,  5,   0,  0, 1, 0, 1);
    cyc("os_halt2",   0, 0, 0, 1, 0, 1, 0,  5,   0,  0, 1, 0, 1);
    // Mode change while halted does not resume counting
    cyc("os_modechg", 0, 0, 0, 1, 1, 0, 0,  5,   0,  0, 1, 0, 1);
    // Load wins over enable, exits halt, clears done
    cyc("os_load9",   0, 0, 1, 1, 1, 0, 9,  5,   9,  0, 0, 0, 0);

    // Priority and boundaries
    cyc("clr_ld_en",  0, 1, 1, 1, 1, 0, 7,  5,   0,  0, 0, 0, 1);
    cyc("load12",     0, 0, 1, 0, 1, 0, 12, 5,  12,  0, 0, 0, 0);
    cyc("over_wrap",  0, 0, 0, 1, 1, 0, 0,  5,   0,  1, 0, 0, 1);
    cyc("after_wrap", 0, 0, 0, 1, 1, 0, 0,  5,   1,  0, 0, 0, 0);
    cyc("rv0_a",      0, 0, 0, 1, 1, 0, 0,  0,   0,  1, 0, 1, 1);
    cyc("rv0_b",      0, 0, 0, 1, 1, 0, 0,  0,   0,  1, 0, 1, 1);
    cyc("rv0_dn",     0, 0, 0, 1, 0, 0, 0,  0,   0,  1, 0, 1, 1);
    cyc("rv0_idle",   0, 0, 0, 0, 0, 0, 0,  0,   0,  0, 0, 1, 1);
    cyc("dn_wrap",    0, 0, 0, 1, 0, 0, 0,  5,   5,  1, 0, 1, 0);
    cyc("dn_after",   0, 0, 0, 1, 0, 0, 0,  5,   4,  0, 0, 0, 0);
    cyc("ld_vs_en",   0, 0, 1, 1, 1, 0, 2,  5,   2,  0, 0, 0, 0);

    // One-shot up, then reset mid-operation from count 7 and from done
    cyc("osu_load4",  0, 0, 1, 0, 1, 1, 4,  5,   4,  0, 0, 0, 0);
    cyc("osu_5",      0, 0, 0, 1, 1, 1, 0,  5,   5,  0, 0, 1, 0);
    cyc("osu_term",   0, 0, 0, 1, 1, 1, 0,  5,   5,  1, 1, 1, 0);
    cyc("osu_halt",   0, 0, 0, 1, 1, 1, 0,  5,   5,  0, 1, 1, 0);
    cyc("rst_done",   1, 0, 0, 1, 1, 1, 0,  5,   0,  0, 0, 0, 1);
    cyc("load7",      0, 0, 1, 0, 1, 0, 7,  5,   7,  0, 0, 0, 0);
    cyc("rst7_a",     1, 0, 0, 1, 1, 0, 0,  5,   0,  0, 0, 0, 1);
    cyc("rst7_b",     1, 0, 0, 1, 1, 0, 0,  5,   0,  0, 0, 0, 1);
`endif

    // Drain the scoreboard within a bounded number of cycles
    @(negedge clk);
    count_enable = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_flex_counter
`default_nettype wire
